// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN lift controller with travel timing and door dwell/hold
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] hall_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [1:0]            direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int TW = $clog2(TRAVEL_CYCLES) > 0 ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = $clog2(DOOR_CYCLES) > 0 ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t                  state, state_d;
  logic [FLOOR_W-1:0]      floor_d, step_floor;
  logic [1:0]              dir_d, dir_sel;
  logic [TW-1:0]           tcnt, tcnt_d;
  logic [DW-1:0]           dcnt, dcnt_d;
  logic [NUM_FLOORS-1:0]   clr, cur_mask, step_mask, absorb;
  logic                    above, below, at_bound, restart, arrive_d;
  assign moving     = state == MOVE;
  assign door_open  = state == DOOR;
  assign cur_mask   = NUM_FLOORS'(1) << current_floor;
  assign step_floor = direction == DIR_DN ? current_floor - 1'b1 : current_floor + 1'b1;
  assign step_mask  = NUM_FLOORS'(1) << step_floor;
  assign at_bound   = direction == DIR_DN ? current_floor == '0 : current_floor == FLOOR_W'(NUM_FLOORS - 1);
  assign restart    = door_hold | hall_req[current_floor] | car_req[current_floor];
  assign absorb     = state == DOOR ? cur_mask : '0;
  assign dir_sel    = direction == DIR_DN ? (below ? DIR_DN : above ? DIR_UP : DIR_IDLE)
                                          : (above ? DIR_UP : below ? DIR_DN : DIR_IDLE);
  // look for latched calls strictly above and strictly below the car
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && i > int'(current_floor)) above = 1'b1;
      if (pending[i] && i < int'(current_floor)) below = 1'b1;
    end
  end
  // next-state, floor, direction, counters and service clear
  always_comb begin
    state_d  = state;
    floor_d  = current_floor;
    dir_d    = direction;
    tcnt_d   = tcnt;
    dcnt_d   = dcnt;
    clr      = '0;
    arrive_d = 1'b0;
    case (state)
      IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (pending[current_floor]) begin
          state_d = DOOR;
          clr     = cur_mask;
        end else if (dir_sel != DIR_IDLE) begin
          state_d = MOVE;
          dir_d   = dir_sel;
        end
      end
      MOVE: begin
        tcnt_d = tcnt + 1'b1;
        if (tcnt == TW'(TRAVEL_CYCLES - 1)) begin
          tcnt_d = '0;
          if (at_bound) begin
            state_d = IDLE;
            dir_d   = DIR_IDLE;
          end else begin
            floor_d = step_floor;
            if (pending[step_floor]) begin
              state_d  = DOOR;
              arrive_d = 1'b1;
              clr      = step_mask;
              dcnt_d   = '0;
            end
          end
        end
      end
      DOOR: begin
        dcnt_d = restart ? '0 : dcnt + 1'b1;
        if (!restart && dcnt == DW'(DOOR_CYCLES - 1)) begin
          dcnt_d  = '0;
          tcnt_d  = '0;
          dir_d   = dir_sel;
          state_d = dir_sel == DIR_IDLE ? IDLE : MOVE;
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_IDLE;
      end
    endcase
  end
  // state register; calls at the open-door floor are absorbed, service clear wins over new sets
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      current_floor <= '0;
      direction     <= DIR_IDLE;
      tcnt          <= '0;
      dcnt          <= '0;
      arrive        <= 1'b0;
      pending       <= '0;
    end else begin
      state         <= state_d;
      current_floor <= floor_d;
      direction     <= dir_d;
      tcnt          <= tcnt_d;
      dcnt          <= dcnt_d;
      arrive        <= arrive_d;
      pending       <= (pending | ((hall_req | car_req) & ~absorb)) & ~clr;
    end
  end
endmodule
